// File: rtl/ray_dispatcher.sv
// ray_dispatcher
//   Scans a FRAME_W x FRAME_H frame in raster order (x fastest) and hands one
//   pixel coordinate per transfer to the ray core. Issue is throttled by the
//   core's fifo_full and by a credit limit of MAX_INFLIGHT unretired pixels.
//   Retired pixels (pixel_valid) are counted. frame_done pulses once every
//   issued pixel has come back.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : begin a frame (honoured only in IDLE)
//   fifo_full       : core input FIFO full, blocks issue
//   pixel_valid     : core retired one pixel this cycle
//   add_input       : transfer strobe (combinational)
//   out_x, out_y    : registered coordinate being presented
//   out_last        : presented coordinate is the final pixel of the frame
//   busy            : not IDLE
//   frame_done      : one-cycle completion pulse (DONE state)
//   inflight        : issued minus retired
//   pixels_retired  : retires since the last accepted start (wraps)
//   underflow       : sticky, a retire arrived with inflight == 0
module ray_dispatcher #(
   parameter int FRAME_W      = 640,
   parameter int FRAME_H      = 480,
   parameter int X_W          = 11,
   parameter int Y_W          = 10,
   parameter int MAX_INFLIGHT = 64,
   localparam int IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            fifo_full,
   input  logic            pixel_valid,
   output logic            add_input,
   output logic [X_W-1:0]  out_x,
   output logic [Y_W-1:0]  out_y,
   output logic            out_last,
   output logic            busy,
   output logic            frame_done,
   output logic [IF_W-1:0] inflight,
   output logic [31:0]     pixels_retired,
   output logic            underflow
);

   localparam logic [X_W-1:0]  X_LAST  = X_W'(FRAME_W - 1);
   localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(FRAME_H - 1);
   localparam logic [IF_W-1:0] CREDITS = IF_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t         state, state_nxt;
   logic           go;
   logic [X_W-1:0] x_nxt;
   logic [Y_W-1:0] y_nxt;

   assign go = (state == IDLE) && start;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = ISSUE;
         ISSUE: if (add_input && out_last) state_nxt = DRAIN;
         // Leave DRAIN on the edge inflight reaches zero, or at once if
         // everything already came back while still issuing.
         DRAIN: if (inflight == '0 || (inflight == IF_W'(1) && pixel_valid))
                   state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      add_input  = (state == ISSUE) && !fifo_full && (inflight < CREDITS);
      busy       = (state != IDLE);
      frame_done = (state == DONE);
   end

   // raster advance: wrap x at the row end and step y
   always_comb begin
      if (out_x == X_LAST) begin
         x_nxt = '0;
         y_nxt = out_y + 1'b1;
      end else begin
         x_nxt = out_x + 1'b1;
         y_nxt = out_y;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_x          <= '0;
         out_y          <= '0;
         out_last       <= 1'b0;
         inflight       <= '0;
         pixels_retired <= '0;
         underflow      <= 1'b0;
      end else begin
         // coordinates: cleared on start, advanced per transfer, frozen on
         // the final pixel so the last coordinate stays visible
         if (go) begin
            out_x    <= '0;
            out_y    <= '0;
            out_last <= (FRAME_W == 1) && (FRAME_H == 1);
         end else if (add_input && !out_last) begin
            out_x    <= x_nxt;
            out_y    <= y_nxt;
            out_last <= (x_nxt == X_LAST) && (y_nxt == Y_LAST);
         end

         // credit counter; survives start so stale pixels still retire
         // against it. A stray retire at zero is clamped.
         case ({add_input, pixel_valid})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
            default: ;
         endcase

         // start clears the frame statistics and takes priority over a
         // retire landing on the same edge
         if (go) begin
            pixels_retired <= '0;
            underflow      <= 1'b0;
         end else if (pixel_valid) begin
            pixels_retired <= pixels_retired + 32'd1;
            if (inflight == '0) underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher: three instances cover the 4x2 frame with ample
// credit, the 4x2 frame with a two-pixel credit limit, and the 1x1 frame.
// Per-cycle vectors drive inputs after the falling edge and compare outputs
// before the next rising edge.
module tb_ray_dispatcher;

   logic clk = 1'b0;
   logic reset;
   logic [2:0] start, ff, pv;

   always #5 clk = ~clk;

   // instance 0: 4x2, 64 credits
   logic a0, l0, b0, d0, u0;
   logic [10:0] x0; logic [9:0] y0; logic [6:0] if0; logic [31:0] r0;
   // instance 1: 4x2, 2 credits
   logic a1, l1, b1, d1, u1;
   logic [10:0] x1; logic [9:0] y1; logic [1:0] if1; logic [31:0] r1;
   // instance 2: 1x1
   logic a2, l2, b2, d2, u2;
   logic [0:0] x2; logic [0:0] y2; logic [6:0] if2; logic [31:0] r2;

   ray_dispatcher #(.FRAME_W(4), .FRAME_H(2), .X_W(11), .Y_W(10), .MAX_INFLIGHT(64)) u_d0 (
      .clk(clk), .reset(reset), .start(start[0]), .fifo_full(ff[0]), .pixel_valid(pv[0]),
      .add_input(a0), .out_x(x0), .out_y(y0), .out_last(l0), .busy(b0), .frame_done(d0),
      .inflight(if0), .pixels_retired(r0), .underflow(u0));

   ray_dispatcher #(.FRAME_W(4), .FRAME_H(2), .X_W(11), .Y_W(10), .MAX_INFLIGHT(2)) u_d1 (
      .clk(clk), .reset(reset), .start(start[1]), .fifo_full(ff[1]), .pixel_valid(pv[1]),
      .add_input(a1), .out_x(x1), .out_y(y1), .out_last(l1), .busy(b1), .frame_done(d1),
      .inflight(if1), .pixels_retired(r1), .underflow(u1));

   ray_dispatcher #(.FRAME_W(1), .FRAME_H(1), .X_W(1), .Y_W(1), .MAX_INFLIGHT(64)) u_d2 (
      .clk(clk), .reset(reset), .start(start[2]), .fifo_full(ff[2]), .pixel_valid(pv[2]),
      .add_input(a2), .out_x(x2), .out_y(y2), .out_last(l2), .busy(b2), .frame_done(d2),
      .inflight(if2), .pixels_retired(r2), .underflow(u2));

   typedef struct {
      int add, x, y, last, busy, done, inf, ret, unf;
   } obs_t;

   obs_t obs [3];

   always_comb begin
      obs[0].add = int'(a0); obs[0].x = int'(x0); obs[0].y = int'(y0); obs[0].last = int'(l0);
      obs[0].busy = int'(b0); obs[0].done = int'(d0); obs[0].inf = int'(if0);
      obs[0].ret = int'(r0); obs[0].unf = int'(u0);
      obs[1].add = int'(a1); obs[1].x = int'(x1); obs[1].y = int'(y1); obs[1].last = int'(l1);
      obs[1].busy = int'(b1); obs[1].done = int'(d1); obs[1].inf = int'(if1);
      obs[1].ret = int'(r1); obs[1].unf = int'(u1);
      obs[2].add = int'(a2); obs[2].x = int'(x2); obs[2].y = int'(y2); obs[2].last = int'(l2);
      obs[2].busy = int'(b2); obs[2].done = int'(d2); obs[2].inf = int'(if2);
      obs[2].ret = int'(r2); obs[2].unf = int'(u2);
   end

   // one cycle of stimulus and the outputs expected during that cycle;
   // ret = -1 means pixels_retired is not compared on that row
   typedef struct {
      int dut;
      bit s, f, p;
      int add, x, y, last, busy, done, inf, ret;
   } vec_t;

   vec_t vq[$];
   int n_chk = 0;
   int n_err = 0;

   task automatic row(input int d, input bit s, input bit f, input bit p,
                      input int a, input int x, input int y, input int l,
                      input int b, input int dn, input int inf, input int ret);
      vec_t v;
      v.dut = d; v.s = s; v.f = f; v.p = p;
      v.add = a; v.x = x; v.y = y; v.last = l;
      v.busy = b; v.done = dn; v.inf = inf; v.ret = ret;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, got, want);
      end
   endtask

   task automatic chk_reset(input int d, input int idx);
      chk("rst add_input", idx, obs[d].add, 0);
      chk("rst out_x", idx, obs[d].x, 0);
      chk("rst out_y", idx, obs[d].y, 0);
      chk("rst out_last", idx, obs[d].last, 0);
      chk("rst busy", idx, obs[d].busy, 0);
      chk("rst frame_done", idx, obs[d].done, 0);
      chk("rst inflight", idx, obs[d].inf, 0);
      chk("rst pixels_retired", idx, obs[d].ret, 0);
      chk("rst underflow", idx, obs[d].unf, 0);
   endtask

   initial begin
      reset = 1'b1; start = '0; ff = '0; pv = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk_reset(d, 1000 + d);
      reset = 1'b0;

      //   dut s f p  add x y last busy done inf ret
      // 4x2 frame, core echoes each transfer 3 cycles later
      row(0, 1,0,0, 0, 0,0, 0, 0,0, 0, 0);
      row(0, 0,0,0, 1, 0,0, 0, 1,0, 0,-1);
      row(0, 0,0,0, 1, 1,0, 0, 1,0, 1,-1);
      row(0, 0,0,0, 1, 2,0, 0, 1,0, 2,-1);
      row(0, 0,0,1, 1, 3,0, 0, 1,0, 3,-1);
      row(0, 0,0,1, 1, 0,1, 0, 1,0, 3,-1);
      row(0, 0,0,1, 1, 1,1, 0, 1,0, 3,-1);
      row(0, 0,0,1, 1, 2,1, 0, 1,0, 3,-1);
      row(0, 0,0,1, 1, 3,1, 1, 1,0, 3,-1);
      row(0, 0,0,1, 0, 3,1, 1, 1,0, 3,-1);
      row(0, 0,0,1, 0, 3,1, 1, 1,0, 2,-1);
      row(0, 0,0,1, 0, 3,1, 1, 1,0, 1,-1);
      row(0, 0,0,0, 0, 3,1, 1, 1,1, 0, 8);
      row(0, 0,0,0, 0, 3,1, 1, 0,0, 0, 8);
      // same frame, fifo_full high for cycles 2-5, start pulsed in ISSUE and DRAIN
      row(0, 1,0,0, 0, 3,1, 1, 0,0, 0,-1);
      row(0, 0,0,0, 1, 0,0, 0, 1,0, 0, 0);
      row(0, 0,1,0, 0, 1,0, 0, 1,0, 1,-1);
      row(0, 1,1,0, 0, 1,0, 0, 1,0, 1, 0);
      row(0, 0,1,1, 0, 1,0, 0, 1,0, 1,-1);
      row(0, 0,1,0, 0, 1,0, 0, 1,0, 0, 1);
      row(0, 0,0,0, 1, 1,0, 0, 1,0, 0,-1);
      row(0, 0,0,0, 1, 2,0, 0, 1,0, 1,-1);
      row(0, 0,0,0, 1, 3,0, 0, 1,0, 2,-1);
      row(0, 0,0,1, 1, 0,1, 0, 1,0, 3,-1);
      row(0, 0,0,1, 1, 1,1, 0, 1,0, 3,-1);
      row(0, 0,0,1, 1, 2,1, 0, 1,0, 3,-1);
      row(0, 0,0,1, 1, 3,1, 1, 1,0, 3,-1);
      row(0, 0,0,1, 0, 3,1, 1, 1,0, 3,-1);
      row(0, 1,0,1, 0, 3,1, 1, 1,0, 2,-1);
      row(0, 0,0,1, 0, 3,1, 1, 1,0, 1,-1);
      row(0, 0,0,0, 0, 3,1, 1, 1,1, 0, 8);
      row(0, 0,0,0, 0, 3,1, 1, 0,0, 0, 8);
      // two credits, retires only where stated
      row(1, 1,0,0, 0, 0,0, 0, 0,0, 0, 0);
      row(1, 0,0,0, 1, 0,0, 0, 1,0, 0,-1);
      row(1, 0,0,0, 1, 1,0, 0, 1,0, 1,-1);
      row(1, 0,0,0, 0, 2,0, 0, 1,0, 2,-1);
      row(1, 0,0,1, 0, 2,0, 0, 1,0, 2,-1);
      row(1, 0,0,0, 1, 2,0, 0, 1,0, 1,-1);
      row(1, 0,0,1, 0, 3,0, 0, 1,0, 2,-1);
      row(1, 0,0,1, 1, 3,0, 0, 1,0, 1,-1);
      row(1, 0,0,0, 1, 0,1, 0, 1,0, 1,-1);
      row(1, 0,0,0, 0, 1,1, 0, 1,0, 2, 3);
      // 1x1 frame
      row(2, 1,0,0, 0, 0,0, 0, 0,0, 0, 0);
      row(2, 0,0,0, 1, 0,0, 1, 1,0, 0,-1);
      row(2, 0,0,0, 0, 0,0, 1, 1,0, 1,-1);
      row(2, 0,0,0, 0, 0,0, 1, 1,0, 1,-1);
      row(2, 0,0,1, 0, 0,0, 1, 1,0, 1,-1);
      row(2, 0,0,0, 0, 0,0, 1, 1,1, 0, 1);
      row(2, 0,0,0, 0, 0,0, 1, 0,0, 0, 1);

      foreach (vq[i]) begin
         @(negedge clk);
         start = '0; ff = '0; pv = '0;
         start[vq[i].dut] = vq[i].s;
         ff[vq[i].dut]    = vq[i].f;
         pv[vq[i].dut]    = vq[i].p;
         #1;
         chk("add_input", i, obs[vq[i].dut].add, vq[i].add);
         chk("out_x", i, obs[vq[i].dut].x, vq[i].x);
         chk("out_y", i, obs[vq[i].dut].y, vq[i].y);
         chk("out_last", i, obs[vq[i].dut].last, vq[i].last);
         chk("busy", i, obs[vq[i].dut].busy, vq[i].busy);
         chk("frame_done", i, obs[vq[i].dut].done, vq[i].done);
         chk("inflight", i, obs[vq[i].dut].inf, vq[i].inf);
         if (vq[i].ret >= 0) chk("pixels_retired", i, obs[vq[i].dut].ret, vq[i].ret);
      end
      @(negedge clk);
      start = '0; ff = '0; pv = '0;

      // mid-frame reset after three transfers, then a stale retire, then restart
      start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("pre-reset out_x", 2000, obs[0].x, 3);
      chk("pre-reset inflight", 2001, obs[0].inf, 3);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1;
      chk_reset(0, 2002);
      pv[0] = 1'b1;
      @(negedge clk); pv[0] = 1'b0;
      #1;
      chk("stale underflow", 2003, obs[0].unf, 1);
      chk("stale pixels_retired", 2004, obs[0].ret, 1);
      chk("stale inflight", 2005, obs[0].inf, 0);
      chk("stale busy", 2006, obs[0].busy, 0);
      start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      #1;
      chk("restart underflow", 2007, obs[0].unf, 0);
      chk("restart pixels_retired", 2008, obs[0].ret, 0);
      chk("restart add_input", 2009, obs[0].add, 1);
      chk("restart out_x", 2010, obs[0].x, 0);
      chk("restart out_y", 2011, obs[0].y, 0);
      chk("restart busy", 2012, obs[0].busy, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
